// File: rtl/fork_sync_param.sv
// fork_sync_param: clocked eager fork. One input token (data + branch mask)
// is broadcast to `size` output branches with independent req/ack handshakes.
// The token retires once every enabled branch has acknowledged it. tok_cnt
// counts retired tokens, including tokens accepted with an all-zero mask,
// which are dropped at once.
// Optional build macro FORK_REG_ACK_EN: ack_in depends only on the held state.
// This breaks the combinational ack_out->ack_in path and halves the peak
// throughput.
module fork_sync_param #(
  parameter int size  = 2,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  output logic              ack_in,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [size-1:0]   mask_in,
  output logic [size-1:0]   req_out,
  input  logic [size-1:0]   ack_out,
  output logic [WIDTH-1:0]  data_out,
  output logic [CNT_W-1:0]  tok_cnt
);

  // valid_q doubles as the FSM state: EMPTY (no token) / HELD (token held)
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HELD  = 1'b1;

  logic              valid_q, valid_d;
  logic [size-1:0]   pend_q,  pend_d;
  logic [WIDTH-1:0]  data_q,  data_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              done_now;
  logic              in_xfer;
  logic [1:0]        retire_inc;

  // Handshake outputs and the "last owed branches finish this cycle" term
  always_comb begin
    done_now = valid_q & ((pend_q & ~ack_out) == {size{1'b0}});
`ifdef FORK_REG_ACK_EN
    ack_in   = ~valid_q;
`else
    ack_in   = ~valid_q | done_now;
`endif
    in_xfer  = req_in & ack_in;
    req_out  = {size{valid_q}} & pend_q;
    data_out = data_q;
    tok_cnt  = cnt_q;
  end

  // Next-state: branch completion, token retire, and loading a new token
  always_comb begin
    valid_d    = valid_q;
    pend_d     = pend_q;
    data_d     = data_q;
    retire_inc = 2'd0;
    case (valid_q)
      ST_EMPTY: begin
        pend_d  = {size{1'b0}};
        valid_d = 1'b0;
      end
      ST_HELD: begin
        // Acks on branches that are no longer owed simply mask to zero
        pend_d = pend_q & ~ack_out;
        if (done_now) begin
          valid_d    = 1'b0;
          retire_inc = 2'd1;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        valid_d = 1'b0;
        pend_d  = {size{1'b0}};
      end
    endcase
    // A new token may land in the same cycle the old one retires
    if (in_xfer) begin
      data_d  = data_in;
      pend_d  = mask_in;
      valid_d = (mask_in != {size{1'b0}});
      // An empty mask means no branch owes anything: retire on acceptance
      if (mask_in == {size{1'b0}}) begin
        retire_inc = retire_inc + 2'd1;
      end else begin
        retire_inc = retire_inc;
      end
    end else begin
      data_d = data_q;
    end
    cnt_d = cnt_q + CNT_W'(retire_inc);
  end

  // State registers with synchronous reset; reset discards a held token uncounted
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pend_q  <= {size{1'b0}};
      data_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fork_sync_param.sv
// Scoreboard bench for fork_sync_param (size=2, WIDTH=8, CNT_W=4 so the
// token counter wraps quickly). The stimulus pushes each accepted token into
// a queue. A negedge monitor keeps a one-slot model (held token and the
// branches still owed) and compares every DUT output with it.
module tb_fork_sync_param;

  localparam int SZ = 2;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          req_in;
  logic          ack_in;
  logic [W-1:0]  data_in;
  logic [SZ-1:0] mask_in;
  logic [SZ-1:0] req_out;
  logic [SZ-1:0] ack_out;
  logic [W-1:0]  data_out;
  logic [CW-1:0] tok_cnt;

  fork_sync_param #(.size(SZ), .WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .ack_in(ack_in),
    .data_in(data_in), .mask_in(mask_in), .req_out(req_out),
    .ack_out(ack_out), .data_out(data_out), .tok_cnt(tok_cnt)
  );

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SZ-1:0] m;
  } tok_t;

  tok_t in_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  initial begin : monitor
    bit           chk_en;
    bit           cur_valid;
    logic [W-1:0] cur_data;
    logic [SZ-1:0] owed;
    logic [SZ-1:0] remaining;
    int           exp_cnt;
    bit           exp_ack;
    tok_t         t;
    chk_en = 1'b0; cur_valid = 1'b0; cur_data = '0; owed = '0; exp_cnt = 0;
    forever begin
      @(negedge clk);
      remaining = owed & ~ack_out;
`ifdef FORK_REG_ACK_EN
      exp_ack = !cur_valid;
`else
      exp_ack = !cur_valid || (remaining == 2'b00);
`endif
      if (chk_en) begin
        chk("req_out", int'(req_out), cur_valid ? int'(owed) : 0);
        chk("data_out", int'(data_out), int'(cur_data));
        chk("tok_cnt", int'(tok_cnt), exp_cnt % (1 << CW));
        chk("ack_in", int'(ack_in), int'(exp_ack));
      end
      if (rst) begin
        cur_valid = 1'b0; cur_data = '0; owed = '0; exp_cnt = 0;
        in_q.delete();
        chk_en = 1'b1;
      end else begin
        if (cur_valid) begin
          owed = remaining;
          if (owed == 2'b00) begin
            cur_valid = 1'b0;
            exp_cnt++;
          end
        end
        if (in_q.size() > 0) begin
          t = in_q.pop_front();
          cur_data = t.d;
          if (t.m == 2'b00) begin
            exp_cnt++;
          end else begin
            cur_valid = 1'b1;
            owed = t.m;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // One cycle of stimulus; records the token if the fork accepted it
  task automatic cycle(input logic r, input logic [W-1:0] d, input logic [SZ-1:0] m,
                       input logic [SZ-1:0] a, output bit acc);
    @(posedge clk);
    #1;
    rst = 1'b0; req_in = r; data_in = d; mask_in = m; ack_out = a;
    #2;
    acc = r && ack_in;
    if (acc) in_q.push_back('{d: d, m: m});
  endtask

  task automatic idle(input logic [SZ-1:0] a);
    bit acc;
    cycle(1'b0, W'($urandom), SZ'($urandom), a, acc);
  endtask

  task automatic send(input logic [W-1:0] d, input logic [SZ-1:0] m,
                      input logic [SZ-1:0] a, output int tries);
    bit acc;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      cycle(1'b1, d, m, a, acc);
      tries++;
    end
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: token %0h not accepted within %0d cycles", d, tries);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1; req_in = 1'b1; ack_out = 2'b11;
      data_in = W'($urandom); mask_in = 2'b11;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : stim
    int tries;
    int exp_tries;
    bit acc;
    rst = 1'b1; req_in = 1'b1; ack_out = 2'b11; data_in = 8'h00; mask_in = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; req_in = 1'b0; ack_out = 2'b00;
    idle(2'b00);

    // Staggered acks
    send(8'hA5, 2'b11, 2'b00, tries);
    idle(2'b00);
    idle(2'b00);
    idle(2'b01);
    idle(2'b00);
    idle(2'b10);
    idle(2'b00);

    // Streaming: one token per cycle (every other cycle with registered ack)
    for (int i = 0; i < 4; i++) begin
      send(8'(i + 1), 2'b11, 2'b11, tries);
`ifdef FORK_REG_ACK_EN
      exp_tries = (i == 0) ? 1 : 2;
`else
      exp_tries = 1;
`endif
      chk("stream_tries", tries, exp_tries);
    end
    idle(2'b11);
    idle(2'b00);

    // Masks: single branch, stray acks on the other, then an all-zero mask
    send(8'h3C, 2'b10, 2'b01, tries);
    idle(2'b01);
    idle(2'b01);
    idle(2'b10);
    idle(2'b00);
    send(8'h77, 2'b00, 2'b00, tries);
    idle(2'b00);

    // Mid-token reset
    send(8'h5A, 2'b11, 2'b00, tries);
    idle(2'b00);
    do_reset(1);
    idle(2'b00);
    idle(2'b00);

    // Counter wrap: 17 tokens into a 4-bit counter
    for (int i = 0; i < 17; i++) send(8'($urandom), 2'b11, 2'b11, tries);
    idle(2'b11);
    idle(2'b00);
    @(negedge clk);
    #1;
    chk("wrap_cnt", int'(tok_cnt), 1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset(1);
      end else begin
        cycle(1'($urandom_range(0, 99) < 70), W'($urandom), SZ'($urandom),
              SZ'($urandom), acc);
      end
    end
    idle(2'b11);
    idle(2'b11);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
